sample_stream_fifo: RTL and testbench

Parametrised successor to the single-byte sample streaming path: a synchronous valid/ready FIFO with configurable data width and depth, fill-level and almost-full reporting, synchronous flush, and an optional running checksum. Sits between a testbench-driven input stream and a consumer in the simulator-interface test designs. Exercises parametrised vectors, memory arrays, handshakes and compile-time optional ports under every supported simulator.

---
 rtl/sample_stream_pkg.sv | 18 +
 rtl/sample_stream_mem.sv | 34 +++
 rtl/sample_stream_fifo.sv | 106 ++++++++++
 tb/tb_sample_stream_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sample_stream_pkg.sv
// Shared width helpers and run-state type for the sample stream FIFO.
package sample_stream_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_stream_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module sample_stream_mem
    import sample_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] w_entries [DEPTH];

    // One named block per entry keeps each stored word visible in the hierarchy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [DATA_WIDTH-1:0] r_word;

        always_ff @(posedge i_clk) begin
            if (i_we && (i_waddr == PTR_W'(g))) begin
                r_word <= i_wdata;
            end
        end

        assign w_entries[g] = r_word;
    end

    assign o_rdata = w_entries[i_raddr];

endmodule

// File: rtl/sample_stream_fifo.sv
// Valid/ready sample FIFO with fill level, almost-full and synchronous flush.
// Define SAMPLE_STREAM_CHECKSUM_EN to add the running checksum output.
module sample_stream_fifo
    import sample_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_flush,
    input  logic                         i_stream_in_valid,
    output logic                         o_stream_in_ready,
    input  logic [DATA_WIDTH-1:0]        i_stream_in_data,
    output logic                         o_stream_out_valid,
    input  logic                         i_stream_out_ready,
    output logic [DATA_WIDTH-1:0]        o_stream_out_data,
    output logic [cnt_width(DEPTH)-1:0]  o_fill_level,
    output logic                         o_almost_full
`ifdef SAMPLE_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]        o_checksum_out
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    run_state_e       r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Ready is gated by flush so a flushing edge can never also accept a word.
    assign o_stream_in_ready  = (r_state == RUN) && (r_count < CNT_W'(DEPTH)) && !i_flush;
    assign o_stream_out_valid = (r_count != '0);
    assign o_fill_level       = r_count;
    assign o_almost_full      = (r_count >= CNT_W'(AFULL_LEVEL));

    assign w_push = i_stream_in_valid && o_stream_in_ready;
    assign w_pop  = o_stream_out_valid && i_stream_out_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= HOLD;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (r_state == HOLD) begin
                r_state <= RUN;
            end
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    sample_stream_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_stream_in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_stream_out_data)
    );

`ifdef SAMPLE_STREAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_checksum <= '0;
        end else if (i_flush) begin
            r_checksum <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + i_stream_in_data;
        end
    end

    assign o_checksum_out = r_checksum;
`endif

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Self-checking bench for sample_stream_fifo (DATA_WIDTH=8, DEPTH=4, AFULL_LEVEL=3).
module tb_sample_stream_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [2:0]    fill;
    logic          afull;
`ifdef SAMPLE_STREAM_CHECKSUM_EN
    logic [DW-1:0] csum;
    logic [DW-1:0] exp_csum = '0;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] sb[$];

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ordy;
        logic          fl;
        logic          e_rdy;
        logic          e_vld;
        logic [2:0]    e_fill;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sample_stream_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFL)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_flush            (flush),
        .i_stream_in_valid  (in_valid),
        .o_stream_in_ready  (in_ready),
        .i_stream_in_data   (in_data),
        .o_stream_out_valid (out_valid),
        .i_stream_out_ready (out_ready),
        .o_stream_out_data  (out_data),
        .o_fill_level       (fill),
        .o_almost_full      (afull)
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        ,
        .o_checksum_out     (csum)
`endif
    );

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic o, logic f,
                                logic r, logic vl, int unsigned fl_lvl);
        vec_t t;
        t.v = v; t.d = d; t.ordy = o; t.fl = f;
        t.e_rdy = r; t.e_vld = vl; t.e_fill = 3'(fl_lvl);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check outputs against expectations, then advance the model past the edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = v.v; in_data = v.d; out_ready = v.ordy; flush = v.fl;
        #1;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(v.e_rdy));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_vld));
        chk({tag, " fill_level"}, 32'(fill), 32'(v.e_fill));
        chk({tag, " almost_full"}, 32'(afull), 32'(v.e_fill >= 3'(AFL)));
        if (v.e_vld) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s out_data: got %0h, expected nothing (scoreboard empty)",
                         tag, out_data);
            end else begin
                chk({tag, " out_data"}, 32'(out_data), 32'(sb[0]));
            end
        end
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        chk({tag, " checksum"}, 32'(csum), 32'(exp_csum));
`endif
        if (v.fl) begin
            sb.delete();
`ifdef SAMPLE_STREAM_CHECKSUM_EN
            exp_csum = '0;
`endif
        end else begin
            if (v.e_vld && v.ordy) void'(sb.pop_front());
            if (v.v && v.e_rdy) begin
                sb.push_back(v.d);
`ifdef SAMPLE_STREAM_CHECKSUM_EN
                exp_csum = exp_csum + v.d;
`endif
            end
        end
    endtask

    initial begin
        // v, data, out_ready, flush, exp_ready, exp_valid, exp_fill (state before the edge)
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 8'hA0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 1, 1, 2));
        vecs.push_back(mk(1, 8'hA3, 0, 0, 1, 1, 3));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 4));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 1, 4));
        vecs.push_back(mk(1, 8'hA4, 1, 0, 0, 1, 4));
        vecs.push_back(mk(1, 8'hA4, 1, 0, 1, 1, 3));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 3));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 2));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hB0, 1, 0, 1, 0, 0));
        for (int i = 1; i < 10; i++) vecs.push_back(mk(1, 8'(8'hB0 + i), 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 8'hC0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hC1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 8'hC2, 0, 0, 1, 1, 2));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 3));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 8'hD0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1));

        // Reset held with a word already offered.
        in_valid = 1'b1; in_data = 8'h11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset fill_level", 32'(fill), 32'd0);
        chk("reset almost_full", 32'(afull), 32'd0);
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        chk("reset checksum", 32'(csum), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready before first edge", 32'(in_ready), 32'd0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("v%0d", i));

        // Checksum sequence: 0x80+0x90+0x05 wraps to 0x15, then flush clears it.
        step(mk(0, 8'h00, 0, 1, 0, 0, 0), "cs_flush0");
        step(mk(1, 8'h80, 0, 0, 1, 0, 0), "cs_push0");
        step(mk(1, 8'h90, 0, 0, 1, 1, 1), "cs_push1");
        step(mk(1, 8'h05, 0, 0, 1, 1, 2), "cs_push2");
        step(mk(0, 8'h00, 0, 0, 1, 1, 3), "cs_idle");
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        chk("checksum 80+90+05", 32'(csum), 32'h15);
`endif
        step(mk(0, 8'h00, 0, 1, 0, 1, 3), "cs_flush1");
        step(mk(0, 8'h00, 0, 0, 1, 0, 0), "cs_after");
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        chk("checksum after flush", 32'(csum), 32'h0);
`endif

        // Reset mid-operation with two words stored clears everything at once.
        step(mk(1, 8'hE0, 0, 0, 1, 0, 0), "mr_push0");
        step(mk(1, 8'hE1, 0, 0, 1, 1, 1), "mr_push1");
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset fill_level", 32'(fill), 32'd0);
        chk("midreset out_valid", 32'(out_valid), 32'd0);
        chk("midreset in_ready", 32'(in_ready), 32'd0);
        chk("midreset almost_full", 32'(afull), 32'd0);
        sb.delete();
`ifdef SAMPLE_STREAM_CHECKSUM_EN
        exp_csum = '0;
        chk("midreset checksum", 32'(csum), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 8'h00, 0, 0, 1, 0, 0), "mr_after");
        step(mk(1, 8'hF0, 0, 0, 1, 0, 0), "mr_push2");
        step(mk(0, 8'h00, 1, 0, 1, 1, 1), "mr_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
